// File: rtl/uart_tx_ctrl.sv
// UART transmit controller.
// Pulls one word from a first-word-fall-through TX FIFO, enables the baud
// timer, and shifts the word out as start bit, DBIT data bits (LSB first)
// and a stop period of SB_TICK oversample ticks. s_tick is the 16x
// oversample pulse from the baud timer.
//
// FIFO handshake: fifo_rd_data is valid whenever fifo_empty is low.
// fifo_rd_en is a combinational single-cycle pop, asserted only in IDLE
// with a non-empty FIFO and reset low. The head word is captured on the
// same clock edge that the pop takes effect, so a word is transferred
// exactly when fifo_rd_en is high at a rising edge.

module uart_tx_ctrl #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    output logic            tmr_en,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_rd_data,
    output logic            fifo_rd_en,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic [1:0]      state_dbg
);

    // The tick counter must reach the larger of the bit and stop periods.
    localparam int CMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int CW   = $clog2(CMAX);
    localparam int BW   = $clog2(DBIT);

    localparam logic [CW-1:0] OVS_LAST  = CW'(OVS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; everything holds when no tick arrives.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Ticks are ignored here, so a tick on the pop cycle is not counted.
                tx_d = 1'b1;
                en_d = 1'b0;
                if (!fifo_empty) begin
                    shift_d = fifo_rd_data;
                    cnt_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (s_tick) begin
                    if (cnt_q == OVS_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        tx_d    = shift_q[0];
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (cnt_q == OVS_LAST) begin
                        cnt_d   = '0;
                        shift_d = shift_q >> 1;
                        if (idx_q == BIT_LAST) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + BW'(1);
                            tx_d  = shift_d[0];
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (cnt_q == STOP_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The pop is combinational so the FIFO advances on the same edge that
    // captures its head word.
    assign fifo_rd_en   = (state_q == IDLE) && !fifo_empty && !rst;

    assign tx           = tx_q;
    assign tmr_en       = en_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (8N1 default and DBIT=7 with a
// 32-tick stop) share clock, reset and tick. Each has its own FIFO queue.
// The reference model tracks only "busy", the byte being sent and the number
// of ticks counted since the pop, and derives the line level from the tick
// position within the frame.

module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s_tick;
    logic       fifo_empty0, fifo_empty1;
    logic [7:0] rd_data0;
    logic [6:0] rd_data1;

    logic       tmr_en0, rd_en0, tx0, busy0, done0;
    logic       tmr_en1, rd_en1, tx1, busy1, done1;
    logic [1:0] state_dbg0, state_dbg1;

    uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .OVS(16)) u0 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tmr_en(tmr_en0),
        .fifo_empty(fifo_empty0), .fifo_rd_data(rd_data0), .fifo_rd_en(rd_en0),
        .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0), .state_dbg(state_dbg0)
    );

    uart_tx_ctrl #(.DBIT(7), .SB_TICK(32), .OVS(16)) u1 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tmr_en(tmr_en1),
        .fifo_empty(fifo_empty1), .fifo_rd_data(rd_data1), .fifo_rd_en(rd_en1),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1), .state_dbg(state_dbg1)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d @%0t: got %0h expected %0h",
                      name, inst, $time, act, exp);
    endtask

    // ---------------- FIFOs ----------------
    logic [7:0] fq0[$];
    logic [6:0] fq1[$];
    logic [7:0] junk0;
    logic [6:0] junk1;
    bit         rd_seen[2];

    task automatic refresh();
        fifo_empty0 = (fq0.size() == 0);
        fifo_empty1 = (fq1.size() == 0);
        rd_data0    = fifo_empty0 ? 8'h00 : fq0[0];
        rd_data1    = fifo_empty1 ? 7'h00 : fq1[0];
    endtask

    task automatic push(input int i, input logic [7:0] v);
        if (i == 0) fq0.push_back(v);
        else        fq1.push_back(v[6:0]);
        refresh();
    endtask

    // ---------------- tick generation and stepping ----------------
    int tick_mode = 0;  // 0: none, 1: every tick_per clk, 2: random 1-in-tick_per
    int tick_per  = 4;
    int tick_ctr  = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rd_seen[0] && fq0.size() > 0) junk0 = fq0.pop_front();
        if (rd_seen[1] && fq1.size() > 0) junk1 = fq1.pop_front();
        tick_ctr++;
        case (tick_mode)
            1:       s_tick = ((tick_ctr % tick_per) == 0);
            2:       s_tick = ($urandom_range(0, tick_per - 1) == 0);
            default: s_tick = 1'b0;
        endcase
        refresh();
    endtask

    // ---------------- accessors ----------------
    function automatic logic tx_of(input int i);    return (i == 0) ? tx0 : tx1; endfunction
    function automatic logic busy_of(input int i);  return (i == 0) ? busy0 : busy1; endfunction
    function automatic logic en_of(input int i);    return (i == 0) ? tmr_en0 : tmr_en1; endfunction
    function automatic logic done_of(input int i);  return (i == 0) ? done0 : done1; endfunction
    function automatic logic rden_of(input int i);  return (i == 0) ? rd_en0 : rd_en1; endfunction
    function automatic logic empty_of(input int i); return (i == 0) ? fifo_empty0 : fifo_empty1; endfunction
    function automatic logic [8:0] head_of(input int i);
        return (i == 0) ? {1'b0, rd_data0} : {2'b00, rd_data1};
    endfunction

    // ---------------- reference model ----------------
    int         dbit_a[2] = '{8, 7};
    int         sbt_a[2]  = '{16, 32};
    bit         m_busy[2];
    int         m_k[2];
    logic [8:0] m_dat[2];
    bit         m_done[2];
    bit         m_valid = 1'b0;

    function automatic int total(input int i);
        return 16 * (1 + dbit_a[i]) + sbt_a[i];
    endfunction

    // Line level from the tick position: slot 0 is the start bit, slots
    // 1..DBIT the data bits LSB first, anything later is stop (high).
    function automatic logic exp_tx(input int i);
        int slot;
        if (!m_busy[i]) return 1'b1;
        slot = m_k[i] / 16;
        if (slot == 0) return 1'b0;
        if (slot <= dbit_a[i]) return m_dat[i][slot-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit         b;
        bit         d;
        int         k;
        logic [8:0] dat;
        for (int i = 0; i < 2; i++) begin
            b   = m_busy[i];
            k   = m_k[i];
            dat = m_dat[i];
            d   = 1'b0;
            if (rst) begin
                b = 1'b0;
                k = 0;
            end else if (!b) begin
                if (!empty_of(i)) begin
                    b   = 1'b1;
                    k   = 0;
                    dat = head_of(i);
                end
            end else if (s_tick) begin
                k = k + 1;
                if (k == total(i)) begin
                    b = 1'b0;
                    d = 1'b1;
                end
            end
            m_busy[i] <= b;
            m_k[i]    <= k;
            m_dat[i]  <= dat;
            m_done[i] <= d;
        end
        if (rst) m_valid <= 1'b1;
    end

    // ---------------- compare and frame capture ----------------
    bit          cap_active[2];
    int          cap_cnt[2];
    logic [15:0] cap_bits[2];
    int          done_cnt[2];
    int          pop_cnt[2];
    int          coincide_cnt = 0;
    logic [15:0] hist0[$], hist1[$];
    int          hlen0[$], hlen1[$];

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                check("tx",           i, {31'd0, tx_of(i)},   {31'd0, exp_tx(i)});
                check("tx_busy",      i, {31'd0, busy_of(i)}, {31'd0, m_busy[i]});
                check("tmr_en",       i, {31'd0, en_of(i)},   {31'd0, m_busy[i]});
                check("tx_done_tick", i, {31'd0, done_of(i)}, {31'd0, m_done[i]});
                check("fifo_rd_en",   i, {31'd0, rden_of(i)},
                      {31'd0, (!m_busy[i] && !empty_of(i) && !rst)});

                if (rst) begin
                    cap_active[i] = 1'b0;
                end else begin
                    if (done_of(i)) begin
                        done_cnt[i]++;
                        if (i == 0 && rden_of(0)) coincide_cnt++;
                        if (cap_active[i]) begin
                            if (i == 0) begin hist0.push_back(cap_bits[0]); hlen0.push_back(cap_cnt[0]); end
                            else        begin hist1.push_back(cap_bits[1]); hlen1.push_back(cap_cnt[1]); end
                        end
                        cap_active[i] = 1'b0;
                    end
                    if (cap_active[i] && s_tick) begin
                        if ((cap_cnt[i] % 16) == 8 && (cap_cnt[i] / 16) < 16)
                            cap_bits[i][cap_cnt[i] / 16] = tx_of(i);
                        cap_cnt[i]++;
                    end
                    if (rden_of(i)) begin
                        cap_active[i] = 1'b1;
                        cap_cnt[i]    = 0;
                        cap_bits[i]   = '0;
                        pop_cnt[i]++;
                    end
                end
            end
        end
        rd_seen[0] = rd_en0;
        rd_seen[1] = rd_en1;
    end

    // ---------------- bounded waits ----------------
    task automatic wait_done(input int i, input int target, input int budget);
        int n = 0;
        while (done_cnt[i] < target && n < budget) begin
            step();
            n++;
        end
        check("wait_done", i, {31'd0, (done_cnt[i] >= target)}, 32'd1);
    endtask

    task automatic wait_ticks0(input int target, input int budget);
        int n = 0;
        while (!(cap_active[0] && cap_cnt[0] >= target) && n < budget) begin
            step();
            n++;
        end
        check("wait_ticks", 0, {31'd0, (cap_active[0] && cap_cnt[0] >= target)}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        rst    = 1'b1;
        s_tick = 1'b0;
        refresh();
        push(0, 8'hA5);
        push(1, 8'h55);

        // Reset held with data waiting: nothing may be popped.
        repeat (3) step();
        check("rst_no_pop",  0, fq0.size(), 32'd1);
        check("rst_no_pop",  1, fq1.size(), 32'd1);
        check("rst_tx",      0, {31'd0, tx0}, 32'd1);
        check("rst_busy",    0, {31'd0, busy0}, 32'd0);
        check("rst_tmr_en",  0, {31'd0, tmr_en0}, 32'd0);
        check("rst_state",   0, {30'd0, state_dbg0}, 32'd0);
        check("rst_state",   1, {30'd0, state_dbg1}, 32'd0);

        // Single frame, tick every 4 clk.
        rst       = 1'b0;
        tick_mode = 1;
        tick_per  = 4;
        wait_done(0, 1, 3000);
        wait_done(1, 1, 3000);
        check("bits_A5",   0, {22'd0, hist0[0][9:0]}, 32'b1101001010);
        check("len_A5",    0, hlen0[0], 32'd160);
        check("bits_55",   1, {22'd0, hist1[0][9:0]}, 32'b1110101010);
        check("len_55",    1, hlen1[0], 32'd160);
        check("pops_1",    0, pop_cnt[0], 32'd1);
        check("pops_1",    1, pop_cnt[1], 32'd1);

        // Back-to-back frames with random ticks.
        tick_mode = 2;
        tick_per  = 3;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(1, 8'($urandom_range(0, 127)));
        push(1, 8'($urandom_range(0, 127)));
        wait_done(0, 3, 4000);
        wait_done(1, 3, 4000);
        check("bits_00",   0, {22'd0, hist0[1][9:0]}, 32'b1000000000);
        check("bits_FF",   0, {22'd0, hist0[2][9:0]}, 32'b1111111110);
        check("len_FF",    0, hlen0[2], 32'd160);
        check("done_pop_same_cycle", 0, coincide_cnt, 32'd1);

        // Tick stall in the middle of the data bits.
        tick_mode = 1;
        tick_per  = 2;
        push(0, 8'h96);
        push(1, 8'($urandom_range(0, 127)));
        wait_ticks0(16 * 3 + 4, 2000);
        tick_mode = 0;
        repeat (50) step();
        tick_mode = 1;
        wait_done(0, 4, 2000);
        wait_done(1, 4, 2000);
        check("bits_96",   0, {22'd0, hist0[3][9:0]}, 32'b1100101100);
        check("len_96",    0, hlen0[3], 32'd160);

        // Reset during data bit 3 of 8'h3C.
        push(0, 8'h3C);
        push(1, 8'($urandom_range(0, 127)));
        wait_ticks0(16 * 4 + 5, 2000);
        rst = 1'b1;
        step();
        check("abort_tx",   0, {31'd0, tx0}, 32'd1);
        check("abort_busy", 0, {31'd0, busy0}, 32'd0);
        rst = 1'b0;
        repeat (20) step();
        check("abort_no_done", 0, done_cnt[0], 32'd4);
        check("abort_no_done", 1, done_cnt[1], 32'd4);
        push(0, 8'h5A);
        push(1, 8'($urandom_range(0, 127)));
        wait_done(0, 5, 2000);
        wait_done(1, 5, 2000);
        check("bits_5A",   0, {22'd0, hist0[4][9:0]}, 32'b1010110100);
        check("len_5A",    0, hlen0[4], 32'd160);
        check("pops_6",    0, pop_cnt[0], 32'd6);

        // Random traffic: bytes arriving at random times, random tick rates.
        for (int n = 0; n < 6; n++) begin
            tick_mode = 1 + int'($urandom_range(0, 1));
            tick_per  = int'($urandom_range(1, 4));
            push(0, 8'($urandom_range(0, 255)));
            push(1, 8'($urandom_range(0, 127)));
            repeat ($urandom_range(0, 300)) step();
        end
        tick_mode = 2;
        tick_per  = 2;
        wait_done(0, 11, 20000);
        wait_done(1, 11, 20000);
        repeat (5) step();
        check("final_done", 0, done_cnt[0], 32'd11);
        check("final_done", 1, done_cnt[1], 32'd11);
        check("final_pops", 0, pop_cnt[0], 32'd12);
        check("final_pops", 1, pop_cnt[1], 32'd12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller that pulls bytes from the TX FIFO, enables the baud timer, and serialises each byte into a UART frame. A frame is one start bit, DBIT data bits sent LSB first, and a stop period of SB_TICK oversample ticks. The oversample tick is the baud timer's `done` pulse, which runs at 16x the baud rate. The block sits between the TX FIFO read port and the `tx` pin.

Parameters:
DBIT, 8, number of data bits per frame (5..9)
SB_TICK, 16, stop period length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
OVS, 16, oversample ticks per start or data bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_tick  in  1  oversample tick, single-cycle pulse from baud timer `done`
tmr_en  out  1  baud timer enable
fifo_empty  in  1  TX FIFO empty flag
fifo_rd_data  in  DBIT  FIFO head word; first-word-fall-through, valid whenever fifo_empty=0
fifo_rd_en  out  1  pops FIFO head; single-cycle pulse
tx  out  1  serial line; idle high
tx_busy  out  1  high while a frame is in progress
tx_done_tick  out  1  single-cycle pulse at end of stop period

Behaviour:
- Reset is synchronous, active-high; `rst` wins over all other inputs. Reset values:
  - state=IDLE, tx=1, tmr_en=0, tx_busy=0, fifo_rd_en=0, tx_done_tick=0
  - tick counter=0, bit index=0, shift register=0
- Reset mid-frame aborts the frame. `tx` returns to 1 on the next edge. No pop, no done pulse.
- States: IDLE, START, DATA, STOP. All outputs are registered except `fifo_rd_en`.
- `fifo_rd_en` = (state==IDLE) & ~fifo_empty & ~rst. It is combinational and high for exactly one cycle per frame.
- IDLE:
  - `tx`=1, `tmr_en`=0. `s_tick` is ignored.
  - If ~fifo_empty: on the same edge, load shift register from `fifo_rd_data`, clear tick counter, go to START, set `tx`<=0, `tmr_en`<=1, `tx_busy`<=1.
- START:
  - On each `s_tick`, tick counter increments.
  - On the `s_tick` where counter==OVS-1: clear counter, clear bit index, `tx`<=shift[0], go to DATA.
- DATA:
  - On the `s_tick` where counter==OVS-1: clear counter and shift right.
  - If bit index==DBIT-1: `tx`<=1, go to STOP. Otherwise bit index++ and `tx`<=next shift[0].
- STOP:
  - On the `s_tick` where counter==SB_TICK-1: go to IDLE, `tx_done_tick`<=1 for one cycle, `tmr_en`<=0, `tx_busy`<=0.
- Cycles without `s_tick` hold all state. A tick on the pop cycle is not counted.
- Counter width is clog2(max(OVS,SB_TICK)). Bit index width is clog2(DBIT).
- Frame length is exactly OVS*(1+DBIT)+SB_TICK ticks: 160 for defaults.
- Back-to-back frames:
  - The IDLE cycle after STOP may pop immediately, giving 1 clk of idle-high gap minimum.
  - `tx_done_tick` and the next `fifo_rd_en` may coincide.
- FIFO becoming empty mid-frame has no effect on the current frame.
- `fifo_rd_data` is sampled only on the pop cycle.

Test Plan:
- Reset: assert rst for 3 clk with fifo_empty=0 -> tx=1, tx_busy=0, fifo_rd_en=0, tmr_en=0, no pop.
- Single byte: s_tick every 4 clk, FIFO holds 8'hA5 ->
  - one fifo_rd_en pulse;
  - tx line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; stop lasts 16 ticks;
  - tx_done_tick after 160 ticks; tx_busy high throughout.
- Back-to-back: FIFO holds 8'h00 then 8'hFF -> two pops; second start bit begins 1 clk after first tx_done_tick; bitstream matches both frames.
- Tick stall: s_tick held 0 for 50 clk mid-DATA -> tx and bit position unchanged; frame resumes correctly when ticks restart.
- Reset mid-frame: rst during bit 3 of 8'h3C -> tx=1 next clk, tx_done_tick never pulses; next FIFO byte sends a full frame.
- Parameters: DBIT=7, SB_TICK=32 with 7'h55 -> 7 data bits, stop lasts 32 ticks, total 160 ticks.
